spike_rate_encoder: RTL and testbench

- Converts a synaptic-sum count into an evenly spaced spike train over a fixed window of W = 2**(n_stage+1) cycles.
- Emits exactly `count` spikes per window, as one bit per cycle.
- Sits downstream of the adder-tree popcount, or at the input of the LIF array. It turns a count back into a rate-coded spike stream that can be fed to neuron inputs.
- Uses a valid/ready load handshake and a Bresenham-style phase accumulator.

---
 rtl/spike_rate_encoder.sv | 79 +++++++
 tb/tb_spike_rate_encoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_encoder.sv
// Rate encoder: turns a count into an evenly spaced spike train over a
// window of 2**(n_stage+1) cycles using a Bresenham phase accumulator.
module spike_rate_encoder #(
   parameter int n_stage = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [n_stage+1:0] count,
   output logic             spike_out,
   output logic             busy,
   output logic             done
);

   localparam int cw = n_stage + 2;
   localparam int sw = n_stage + 1;
   localparam logic [cw-1:0] win       = {1'b1, {sw{1'b0}}};
   localparam logic [sw-1:0] last_slot = '1;

   typedef enum logic {idle, run} state_t;

   state_t          state;
   logic [cw-1:0]   acc;
   logic [cw-1:0]   cnt_reg;
   logic [sw-1:0]   slot;
   logic [cw-1:0]   cnt_sat;
   logic [cw-1:0]   sum_run;

   // acc holds the phase for the next slot, so spike_out is registered
   // one step ahead and is stable for the whole slot.
   always_comb begin
      cnt_sat = (count > win) ? win : count;
      sum_run = acc + cnt_reg;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= idle;
         acc       <= '0;
         cnt_reg   <= '0;
         slot      <= '0;
         spike_out <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            idle: begin
               done      <= 1'b0;
               spike_out <= 1'b0;
               if (in_valid) begin
                  cnt_reg   <= cnt_sat;
                  slot      <= '0;
                  spike_out <= (cnt_sat >= win);
                  acc       <= (cnt_sat >= win) ? cnt_sat - win : cnt_sat;
                  state     <= run;
               end
            end
            run: begin
               if (slot == last_slot) begin
                  // acc has already wrapped back to zero after a full window
                  state     <= idle;
                  spike_out <= 1'b0;
                  done      <= 1'b1;
                  acc       <= '0;
               end else begin
                  slot      <= slot + 1'b1;
                  spike_out <= (sum_run >= win);
                  acc       <= (sum_run >= win) ? sum_run - win : sum_run;
               end
            end
            default: state <= idle;
         endcase
      end
   end

   assign in_ready = (state == idle);
   assign busy     = (state == run);

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Bench for spike_rate_encoder: per-scenario tasks compared against an
// arithmetic floor-based rate model of the expected spike positions.
module tb_spike_rate_encoder;

   localparam int n_stage = 5;
   localparam int w       = 1 << (n_stage + 1);

   logic                 clk;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic [n_stage+1:0]   count;
   logic                 spike_out;
   logic                 busy;
   logic                 done;

   int checks = 0;
   int errors = 0;
   logic exp_q[$];

   spike_rate_encoder #(.n_stage(n_stage)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .count(count), .spike_out(spike_out), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected spike in slot t: increment of floor(t*c/W), c saturated at W.
   function automatic logic ref_spike(input int c, input int t);
      int cs;
      cs = (c > w) ? w : c;
      return (((t + 1) * cs) / w) != ((t * cs) / w);
   endfunction

   task automatic load_model(input int c);
      exp_q.delete();
      for (int t = 0; t < w; t++) exp_q.push_back(ref_spike(c, t));
   endtask

   // Called at a negedge while idle; returns just after the accepting edge.
   task automatic start(input int c);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL start_ready: in_ready=%b expected 1", in_ready);
      end
      in_valid = 1'b1;
      count    = c[n_stage+1:0];
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Checks every slot and the done cycle; ends at the done cycle's negedge.
   task automatic check_window(input int c, input string name, input int pulse_slot);
      int   total;
      int   cs;
      logic e;
      total = 0;
      cs    = (c > w) ? w : c;
      load_model(c);
      for (int t = 0; t < w; t++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (spike_out !== e || busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s slot %0d: spike=%b busy=%b done=%b ready=%b expected spike=%b busy=1 done=0 ready=0",
                     name, t, spike_out, busy, done, in_ready, e);
         end
         if (spike_out === 1'b1) total++;
         if (t == pulse_slot) begin
            in_valid = 1'b1;
            count    = 7'd5;
         end else if (t == pulse_slot + 1) begin
            in_valid = 1'b0;
         end
      end
      checks++;
      if (total != cs) begin
         errors++;
         $display("FAIL %s total: spikes=%0d expected %0d", name, total, cs);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || spike_out !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s done_cycle: done=%b busy=%b spike=%b ready=%b expected 1 0 0 1",
                  name, done, busy, spike_out, in_ready);
      end
   endtask

   task automatic check_idle(input string name);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || spike_out !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s idle: done=%b busy=%b spike=%b ready=%b expected 0 0 0 1",
                  name, done, busy, spike_out, in_ready);
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 1'b1;
      count    = 7'd10;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b1 || spike_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: ready=%b spike=%b busy=%b done=%b expected 1 0 0 0",
                     in_ready, spike_out, busy, done);
         end
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      check_window(10, "first_accept", -1);
      check_idle("after_first");
   endtask

   task automatic test_counts();
      int tbl[5] = '{32, 1, 64, 0, 100};
      foreach (tbl[i]) begin
         start(tbl[i]);
         check_window(tbl[i], $sformatf("count_%0d", tbl[i]), -1);
         check_idle($sformatf("count_%0d", tbl[i]));
      end
   endtask

   task automatic test_ignore_valid();
      start(32);
      check_window(32, "ignore_valid", 10);
      check_idle("ignore_valid_post");
      check_idle("ignore_valid_post2");
   endtask

   task automatic test_back_to_back();
      start(3);
      check_window(3, "b2b_first", -1);
      start(7);
      check_window(7, "b2b_second", -1);
      check_idle("b2b_post");
   endtask

   task automatic test_mid_reset();
      start(40);
      load_model(40);
      for (int t = 0; t <= 20; t++) begin
         @(negedge clk);
         checks++;
         if (spike_out !== exp_q[t] || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset slot %0d: spike=%b busy=%b expected spike=%b busy=1",
                     t, spike_out, busy, exp_q[t]);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || spike_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_async: ready=%b spike=%b busy=%b done=%b expected 1 0 0 0",
                  in_ready, spike_out, busy, done);
      end
      repeat (2) check_idle("mid_reset_hold");
      rst_n = 1'b1;
      check_idle("mid_reset_release");
      start(8);
      check_window(8, "after_reset", -1);
      check_idle("after_reset_post");
   endtask

   task automatic test_random();
      int c;
      for (int i = 0; i < 6; i++) begin
         c = $urandom_range(0, 127);
         start(c);
         check_window(c, $sformatf("rand_%0d", c), -1);
      end
      check_idle("rand_post");
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      count    = '0;
      test_reset();
      test_counts();
      test_ignore_valid();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
